// File: rtl/sio_tx.sv
// Transmit endpoint of the single-wire half-duplex serial link: frames a parallel
// word onto a shared tri-state line, then releases the line for a turnaround window.
module sio_tx #(
    parameter int WIDTH  = 8,
    parameter int DIV    = 4,
    parameter int PARITY = 0,
    parameter int TURN   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    inout  wire              sio,
    output logic             oe,
    output logic             busy,
    output logic             done
);
    localparam int TMR_W   = $clog2(DIV + 1);
    localparam int CNT_MAX = (WIDTH > TURN) ? WIDTH : TURN;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(DIV - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'((TURN > 0) ? (TURN - 1) : 0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4,
        ST_TURN  = 3'd5
    } state_t;

    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        return ^word;
    endfunction

    state_t           state_r, state_s;
    logic [TMR_W-1:0] timer_r, timer_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [WIDTH-1:0] shift_r, shift_s;
    logic             par_r, par_s;
    logic             sio_bit_r, sio_bit_s;
    logic             ready_s, oe_s, busy_s, done_s;
    logic             wrap_s;

    // Next-state, bit timer, bit/turnaround counter and shift register update
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        cnt_s   = cnt_r;
        shift_s = shift_r;
        par_s   = par_r;
        done_s  = 1'b0;
        wrap_s  = (timer_r == TMR_LAST);

        if (state_r == ST_IDLE) begin
            timer_s = {TMR_W{1'b0}};
        end else if (wrap_s) begin
            timer_s = {TMR_W{1'b0}};
        end else begin
            timer_s = timer_r + TMR_W'(1);
        end

        case (state_r)
            ST_IDLE: begin
                if (valid && ready) begin
                    state_s = ST_START;
                    shift_s = data;
                    par_s   = even_parity(data);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (wrap_s) begin
                    state_s = ST_DATA;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (wrap_s && (cnt_r == DATA_LAST)) begin
                    state_s = (PARITY != 0) ? ST_PAR : ST_STOP;
                end else if (wrap_s) begin
                    cnt_s   = cnt_r + CNT_W'(1);
                    shift_s = shift_r >> 1;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PAR: begin
                if (wrap_s) begin
                    state_s = ST_STOP;
                end else begin
                    state_s = ST_PAR;
                end
            end
            ST_STOP: begin
                if (wrap_s && (TURN > 0)) begin
                    state_s = ST_TURN;
                    cnt_s   = {CNT_W{1'b0}};
                end else if (wrap_s) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_STOP;
                end
            end
            ST_TURN: begin
                if (wrap_s && (cnt_r == TURN_LAST)) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else if (wrap_s) begin
                    cnt_s = cnt_r + CNT_W'(1);
                end else begin
                    state_s = ST_TURN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output values are decoded from the upcoming state so they register in step with it
    always_comb begin
        ready_s   = 1'b0;
        busy_s    = 1'b1;
        oe_s      = 1'b0;
        sio_bit_s = 1'b0;
        case (state_s)
            ST_IDLE: begin
                ready_s = 1'b1;
                busy_s  = 1'b0;
            end
            ST_START: begin
                oe_s      = 1'b1;
                sio_bit_s = 1'b0;
            end
            ST_DATA: begin
                oe_s      = 1'b1;
                sio_bit_s = shift_s[0];
            end
            ST_PAR: begin
                oe_s      = 1'b1;
                sio_bit_s = par_s;
            end
            ST_STOP: begin
                oe_s      = 1'b1;
                sio_bit_s = 1'b1;
            end
            ST_TURN: begin
                oe_s = 1'b0;
            end
            default: begin
                ready_s = 1'b1;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset releases the line and suppresses done
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            timer_r   <= {TMR_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            shift_r   <= {WIDTH{1'b0}};
            par_r     <= 1'b0;
            sio_bit_r <= 1'b0;
            ready     <= 1'b1;
            oe        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_r   <= state_s;
            timer_r   <= timer_s;
            cnt_r     <= cnt_s;
            shift_r   <= shift_s;
            par_r     <= par_s;
            sio_bit_r <= sio_bit_s;
            ready     <= ready_s;
            oe        <= oe_s;
            busy      <= busy_s;
            done      <= done_s;
        end
    end

    assign sio = oe ? sio_bit_r : 1'bz;

endmodule

// File: tb/tb_sio_tx.sv
// Scoreboard bench for sio_tx: four parameter sets run side by side, each with a
// random/directed driver pushing expected line activity and a monitor popping it.
module tb_sio_tx;
    logic clk;
    int   checks;
    int   errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
        end
    endfunction

    for (genvar g = 0; g < 4; g++) begin : cfg
        localparam int W = (g == 2) ? 4 : ((g == 3) ? 5 : 8);
        localparam int D = (g == 2) ? 1 : ((g == 3) ? 3 : 4);
        localparam int P = ((g == 1) || (g == 3)) ? 1 : 0;
        localparam int T = (g == 2) ? 0 : ((g == 3) ? 1 : 2);
        localparam int FIRST = (g == 0) ? 'hA5 : ((g == 1) ? 'h07 : ((g == 2) ? 'hC : 'h13));
        localparam int FRAME_CYC = (2 + W + P + T) * D + 1;

        logic         reset;
        logic         valid;
        logic [W-1:0] data;
        logic         ready, oe, busy, done;
        wire          sio;
        int           code_q[$];
        longint       start_q[$];
        bit           stim_done;

        sio_tx #(.WIDTH(W), .DIV(D), .PARITY(P), .TURN(T)) dut (
            .clk(clk), .reset(reset), .data(data), .valid(valid),
            .ready(ready), .sio(sio), .oe(oe), .busy(busy), .done(done)
        );

        // Reference: per-cycle line codes (0/1 driven bit, 2 released, 3 done), +4 marks frame start
        function automatic void expect_frame(int word, longint t_acc);
            int bits[$];
            int ones;
            int first;
            ones  = 0;
            first = 4;
            bits.push_back(0);
            for (int i = 0; i < W; i++) begin
                bits.push_back((word >> i) & 1);
                ones += (word >> i) & 1;
            end
            if (P != 0) bits.push_back(ones % 2);
            bits.push_back(1);
            foreach (bits[k]) begin
                for (int c = 0; c < D; c++) begin
                    code_q.push_back(bits[k] + first);
                    first = 0;
                end
            end
            for (int c = 0; c < T * D; c++) code_q.push_back(2);
            code_q.push_back(3);
            start_q.push_back(t_acc);
        endfunction

        task automatic cycle(input logic v, input logic [W-1:0] d, input logic rst);
            logic acc;
            valid = v;
            data  = d;
            reset = rst;
            @(negedge clk);
            acc = v && ready && !rst;
            @(posedge clk);
            if (acc) expect_frame(int'(d), $time);
            if (rst) begin
                code_q.delete();
                start_q.delete();
            end
            #1;
        endtask

        task automatic idle(input int n);
            for (int i = 0; i < n; i++) cycle(1'b0, W'($urandom), 1'b0);
        endtask

        initial begin
            stim_done = 1'b0;
            repeat (4) cycle(1'b1, W'($urandom), 1'b1);
            cycle(1'b1, W'(FIRST), 1'b0);
            idle(FRAME_CYC + 4);
            cycle(1'b1, W'(1), 1'b0);
            for (int i = 0; i < 2 * FRAME_CYC + 3; i++) cycle(1'b1, {W{1'b1}}, 1'b0);
            idle(FRAME_CYC + 2);
            for (int i = 0; i < 8 * FRAME_CYC; i++) cycle(1'($urandom_range(0, 1)), W'($urandom), 1'b0);
            idle(FRAME_CYC + 2);
            // reset lands inside data bit 3
            cycle(1'b1, W'($urandom), 1'b0);
            idle(4 * D + D / 2);
            cycle(1'b1, W'($urandom), 1'b1);
            cycle(1'b1, W'($urandom), 1'b0);
            idle(FRAME_CYC + 4);
            check($sformatf("cfg%0d drained", g), code_q.size(), 0);
            stim_done = 1'b1;
        end

        initial begin
            int c;
            int exp_v;
            int act_v;
            @(posedge clk);
            forever begin
                @(negedge clk);
                act_v = int'({done, busy, ready, oe, (oe ? sio : 1'b0)});
                if (busy || done) begin
                    if (code_q.size() == 0) begin
                        check($sformatf("cfg%0d unexpected_activity", g), act_v, 5'b00100);
                    end else begin
                        c = code_q.pop_front();
                        if (c >= 4) begin
                            c -= 4;
                            check($sformatf("cfg%0d start_latency", g), int'($time - start_q.pop_front()), 5);
                        end
                        case (c)
                            0:       exp_v = 5'b01010;
                            1:       exp_v = 5'b01011;
                            2:       exp_v = 5'b01000;
                            default: exp_v = 5'b10100;
                        endcase
                        check($sformatf("cfg%0d frame_cycle", g), act_v, exp_v);
                    end
                end else begin
                    check($sformatf("cfg%0d idle", g), act_v, 5'b00100);
                end
            end
        end
    end

    initial begin
        int tmo;
        checks = 0;
        errors = 0;
        tmo    = 0;
        while (!(cfg[0].stim_done && cfg[1].stim_done && cfg[2].stim_done && cfg[3].stim_done)
               && (tmo < 20000)) begin
            @(posedge clk);
            tmo++;
        end
        check("all_configs_finished", int'(tmo < 20000), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sio_tx.md
# sio_tx

Transmit endpoint of the single-wire half-duplex serial link used by the port-direction test fixtures. It accepts a parallel word on a valid/ready handshake, serialises it onto a shared `inout` line as a framed bit stream, then releases the line to high-Z for a turnaround window so the far-end receiver can answer. It sits between a word-producing controller and the bidirectional pad.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DIV, 4, clock cycles per bit period (≥1)
- PARITY, 0, 0 = no parity bit; 1 = even parity bit after data
- TURN, 2, bit periods the line stays released after the stop bit (≥0)

- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-high reset
- data  input  WIDTH  word to send; sampled only on accept
- valid  input  1  producer has a word
- ready  output reg  1  block can accept; accept = valid && ready at a rising edge
- sio  inout  1  serial line; driven with the current bit when oe=1, else 1'bz
- oe  output reg  1  output-enable for sio
- busy  output reg  1  high from the cycle after accept until done
- done  output reg  1  one-cycle pulse at end of turnaround

## Operation
- States: IDLE, START, DATA, PAR, STOP, TURN.
- IDLE: ready=1, oe=0, busy=0. On accept, latch data into shift register, go to START.
- START: oe=1, sio=0 for DIV cycles → DATA.
- DATA: sio = shift[0], LSB first, WIDTH bit periods of DIV cycles, shift right each period → PAR if PARITY=1, else STOP.
- PAR: sio = ^latched data (even parity), one bit period → STOP.
- STOP: sio=1, one bit period → TURN if TURN>0, else IDLE with done.
- TURN: oe=0, sio=1'bz, TURN bit periods → IDLE, done=1 for one cycle.
- Bit timer counts 0..DIV-1 and wraps; the state advances on the wrap. The counter is $clog2(DIV+1) bits wide and never overflows for DIV=1.
- valid and data are ignored outside IDLE. Changing data after accept has no effect on the frame.
- ready is low in every state except IDLE. There is no combinational path from valid to ready.

## Timing
- Reset values: ready=1, oe=0, sio=1'bz, busy=0, done=0, state=IDLE, shift register and bit timer cleared.
- Accept at edge N: at N+1 ready=0, busy=1, oe=1, sio=0.
- Frame bits F = 2 + WIDTH + PARITY. The line is driven for exactly F·DIV cycles starting at N+1.
- Turnaround: oe=0 for exactly TURN·DIV cycles after the stop bit.
- done=1, ready=1, busy=0 all first appear at edge N+1+(F+TURN)·DIV. done is 1 for that cycle only.
- Back-to-back: if valid is held, the next accept happens on the first cycle ready=1. That accept coincides with done, so the next START drives one cycle later. There is no idle gap beyond this.
- Reset mid-frame, any state: at the next edge oe=0, line released, all outputs take their reset values. No done pulse is produced.
- TURN=0: STOP goes directly to IDLE. done and ready rise at N+1+F·DIV.

## Test plan
- Defaults, data=8'hA5, valid one cycle: sio sequence per 4-cycle period = 0,1,0,1,0,0,1,0,1,1. Then high-Z for 8 cycles. done at cycle 48 after accept, ready=1 with it.
- PARITY=1, data=8'h07: parity bit = 1. Frame is 11 bits. done 52 cycles after accept.
- valid held high with data 8'h01 then 8'hFF: second START drives the cycle after the first done. valid toggling during the frame does not disturb the frame.
- DIV=1, TURN=0, WIDTH=4, data=4'hC: sio = 0,0,0,1,1,1 on consecutive cycles. done 6 cycles after accept.
- Reset asserted during DATA bit 3: next edge oe=0, sio=z, ready=1, busy=0, no done pulse. A new accept afterwards produces a clean full frame.
- Reset held for several cycles with valid=1: no accept occurs, oe stays 0. The first accept occurs on the first edge after reset deasserts.
